// File: rtl/sram_ctrl_async.sv
// sram_ctrl_async: req/ready front end that sequences reads and writes on an asynchronous SRAM
// Build option: define SRAM_TURNAROUND_EN to add one idle TURN cycle after every read.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req, we, addr, wdata   access request; sampled on the edge where ready=1
//   ready                  controller idle and able to accept req this cycle
//   rdata, rvalid          last read data, one-cycle pulse when rdata updates
//   CSX, OEX, WEX          registered active-low SRAM strobes
//   ADDR                   registered SRAM address
//   DATA                   SRAM data bus, driven only during WR and WR_HOLD
module sram_ctrl_async #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              CSX,
  output logic              OEX,
  output logic              WEX,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DATA
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("sram_ctrl_async: WAIT_CYCLES must be >= 1");
  end
`ifdef SRAM_TURNAROUND_EN
  typedef enum logic [2:0] {IDLE, WR, WR_HOLD, RD, TURN} state_t;
  localparam state_t RD_NEXT = TURN;
`else
  typedef enum logic [1:0] {IDLE, WR, WR_HOLD, RD} state_t;
  localparam state_t RD_NEXT = IDLE;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] wdata_q;
  logic oe, last, accept;
  assign ready  = (state == IDLE) && !reset;
  assign accept = (state == IDLE) && req;
  assign last   = cnt == LAST;
  assign DATA   = oe ? wdata_q : 'z;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (req) begin
        state_n = we ? WR : RD;
        cnt_n   = '0;
      end
      WR: if (last) state_n = WR_HOLD;
          else cnt_n = cnt + 1'b1;
      WR_HOLD: state_n = IDLE;
      RD: if (last) state_n = RD_NEXT;
          else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // Strobes and the bus enable are decoded from the next state so the pins
  // change exactly on the edge that enters each state, with no path from req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      CSX     <= 1'b1;
      OEX     <= 1'b1;
      WEX     <= 1'b1;
      oe      <= 1'b0;
      ADDR    <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      CSX    <= !(state_n == WR || state_n == WR_HOLD || state_n == RD);
      WEX    <= state_n != WR;
      OEX    <= state_n != RD;
      oe     <= state_n == WR || state_n == WR_HOLD;
      rvalid <= state == RD && last;
      if (state == RD && last) rdata <= DATA;
      if (accept) begin
        ADDR    <= addr;
        wdata_q <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_sram_ctrl_async.sv
// tb_sram_ctrl_async: scoreboard bench for sram_ctrl_async against a behavioural SRAM
module tb_sram_ctrl_async;
  localparam int DW = 16;
  localparam int AW = 18;
  localparam int WC = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic ready, rvalid, CSX, OEX, WEX;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ADDR;
  wire  [DW-1:0] DATA;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_q [$];
  logic probe_en = 1'b0;
  logic [DW-1:0] probe_val = '0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_ctrl_async #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rvalid(rvalid),
    .CSX(CSX), .OEX(OEX), .WEX(WEX), .ADDR(ADDR), .DATA(DATA)
  );

  assign DATA = (!CSX && !OEX) ? mem[ADDR] : 'z;
  assign DATA = probe_en ? probe_val : 'z;
  always @(posedge WEX) if (!CSX) mem[ADDR] <= DATA;

  task automatic test_reset;
    #12 reset = 1'b1;
    #1;
    tests++; if ({CSX, OEX, WEX} !== 3'b111) begin fails++; $display("FAIL rst_strobes: got %b want 111", {CSX, OEX, WEX}); end
    tests++; if (rvalid !== 1'b0 || rdata !== '0) begin fails++; $display("FAIL rst_rdata: rvalid=%b rdata=%h want 0 0000", rvalid, rdata); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", ready); end
    tests++; if (ADDR !== '0) begin fails++; $display("FAIL rst_addr: got %h want 00000", ADDR); end
  endtask

  task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_mem[a] = d;
    @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk); req = 1'b0;
    for (int i = 0; i < WC; i++) begin
      tests++; if ({CSX, WEX, OEX} !== 3'b001 || ready !== 1'b0) begin fails++; $display("FAIL wr_strobe[%0d]: CSX/WEX/OEX=%b ready=%b want 001 0", i, {CSX, WEX, OEX}, ready); end
      tests++; if (DATA !== d || ADDR !== a) begin fails++; $display("FAIL wr_bus[%0d]: DATA=%h ADDR=%h want %h %h", i, DATA, ADDR, d, a); end
      @(negedge clk);
    end
    tests++; if ({CSX, WEX, OEX} !== 3'b011 || DATA !== d || ready !== 1'b0) begin fails++; $display("FAIL wr_hold: CSX/WEX/OEX=%b DATA=%h ready=%b want 011 %h 0", {CSX, WEX, OEX}, DATA, ready, d); end
    @(negedge clk);
    tests++; if (ready !== 1'b1 || CSX !== 1'b1) begin fails++; $display("FAIL wr_done: ready=%b CSX=%b want 1 1", ready, CSX); end
    tests++; if (mem[a] !== d) begin fails++; $display("FAIL wr_model: mem=%h want %h", mem[a], d); end
    probe_en = 1'b1; probe_val = ~d;
    #1;
    tests++; if (DATA !== ~d) begin fails++; $display("FAIL idle_hiz: DATA=%h want %h", DATA, ~d); end
    probe_en = 1'b0;
  endtask

  task automatic test_read(input logic [AW-1:0] a);
    logic [DW-1:0] exp;
    exp_q.push_back(ref_mem[a]);
    @(negedge clk); req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk); req = 1'b0;
    for (int i = 0; i < WC; i++) begin
      tests++; if ({CSX, OEX, WEX} !== 3'b001 || rvalid !== 1'b0 || ADDR !== a) begin fails++; $display("FAIL rd_strobe[%0d]: CSX/OEX/WEX=%b rvalid=%b ADDR=%h want 001 0 %h", i, {CSX, OEX, WEX}, rvalid, ADDR, a); end
      tests++; if (DATA !== ref_mem[a]) begin fails++; $display("FAIL rd_bus[%0d]: DATA=%h want %h", i, DATA, ref_mem[a]); end
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    tests++; if (rvalid !== 1'b1) begin fails++; $display("FAIL rd_rvalid: got %b want 1", rvalid); end
    tests++; if (rdata !== exp) begin fails++; $display("FAIL rd_data: got %h want %h", rdata, exp); end
`ifdef SRAM_TURNAROUND_EN
    tests++; if (CSX !== 1'b1 || ready !== 1'b0) begin fails++; $display("FAIL rd_turn: CSX=%b ready=%b want 1 0", CSX, ready); end
`else
    tests++; if (CSX !== 1'b1 || ready !== 1'b1) begin fails++; $display("FAIL rd_idle: CSX=%b ready=%b want 1 1", CSX, ready); end
`endif
    @(negedge clk);
    tests++; if (rvalid !== 1'b0 || rdata !== exp || ready !== 1'b1) begin fails++; $display("FAIL rd_after: rvalid=%b rdata=%h ready=%b want 0 %h 1", rvalid, rdata, ready, exp); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] exp;
    bit got = 0;
    bit bad = 0;
    ref_mem[18'h3FFFF] = 16'hFFFF;
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 18'h3FFFF; wdata = 16'hFFFF;
    for (int i = 0; i < WC + 1; i++) begin
      @(negedge clk);
      tests++; if (CSX !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL b2b_wr[%0d]: CSX=%b ready=%b want 0 0", i, CSX, ready); end
    end
    we = 1'b0;
    exp_q.push_back(ref_mem[18'h3FFFF]);
    @(negedge clk);
    tests++; if (ready !== 1'b1 || CSX !== 1'b1) begin fails++; $display("FAIL b2b_idle: ready=%b CSX=%b want 1 1", ready, CSX); end
    @(negedge clk); req = 1'b0;
    tests++; if (OEX !== 1'b0 || CSX !== 1'b0) begin fails++; $display("FAIL b2b_rd_start: OEX=%b CSX=%b want 0 0", OEX, CSX); end
    for (int i = 0; i < 8 && !got; i++) begin
      if (!OEX && (DATA !== 16'hFFFF || !WEX)) bad = 1;
      if (rvalid) begin
        got = 1;
        exp = exp_q.pop_front();
        tests++; if (rdata !== exp) begin fails++; $display("FAIL b2b_rdata: got %h want %h", rdata, exp); end
      end else @(negedge clk);
    end
    tests++; if (!got) begin fails++; $display("FAIL b2b_timeout: rvalid=%b want 1 within 8 cycles", rvalid); end
    tests++; if (bad) begin fails++; $display("FAIL b2b_contention: flag=%b want 0", bad); end
  endtask

  task automatic test_reset_mid_read;
    bit seen = 0;
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 18'h00012;
    @(posedge clk); #2; req = 1'b0;
    tests++; if (OEX !== 1'b0) begin fails++; $display("FAIL mid_rd_started: OEX=%b want 0", OEX); end
    reset = 1'b1;
    #1;
    tests++; if ({CSX, OEX, WEX} !== 3'b111 || ready !== 1'b0) begin fails++; $display("FAIL mid_rst_strobes: %b ready=%b want 111 0", {CSX, OEX, WEX}, ready); end
    tests++; if (rvalid !== 1'b0 || rdata !== '0) begin fails++; $display("FAIL mid_rst_rdata: rvalid=%b rdata=%h want 0 0000", rvalid, rdata); end
    req = 1'b1;
    @(negedge clk);
    tests++; if (CSX !== 1'b1 || OEX !== 1'b1) begin fails++; $display("FAIL rst_priority: CSX=%b OEX=%b want 1 1", CSX, OEX); end
    reset = 1'b0; req = 1'b0;
    for (int i = 0; i < WC + 3; i++) begin
      @(negedge clk);
      if (rvalid) seen = 1;
    end
    tests++; if (seen) begin fails++; $display("FAIL mid_rst_rvalid: seen=%b want 0", seen); end
  endtask

`ifdef SRAM_TURNAROUND_EN
  task automatic test_turn;
    int oex_rise = -1;
    int wex_fall = -1;
    bit turn_seen = 0;
    logic po, pw;
    exp_q.push_back(ref_mem[18'h00012]);
    ref_mem[18'h00100] = 16'h1234;
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 18'h00012;
    po = OEX; pw = WEX;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin we = 1'b1; addr = 18'h00100; wdata = 16'h1234; end
      if (OEX && !po && oex_rise < 0) oex_rise = i;
      if (!WEX && pw && wex_fall < 0) begin wex_fall = i; req = 1'b0; end
      if (CSX && !ready && rvalid) begin
        logic [DW-1:0] exp;
        turn_seen = 1;
        exp = exp_q.pop_front();
        tests++; if (rdata !== exp) begin fails++; $display("FAIL turn_rdata: got %h want %h", rdata, exp); end
      end
      po = OEX; pw = WEX;
    end
    tests++; if (!turn_seen) begin fails++; $display("FAIL turn_cycle: seen=%b want 1", turn_seen); end
    tests++; if (oex_rise < 0 || wex_fall < 0 || wex_fall - oex_rise < 2) begin fails++; $display("FAIL turn_gap: oex_rise=%0d wex_fall=%0d want gap >= 2", oex_rise, wex_fall); end
    tests++; if (mem[18'h00100] !== 16'h1234) begin fails++; $display("FAIL turn_write: mem=%h want 1234", mem[18'h00100]); end
  endtask
`endif

  initial begin
    test_reset();
    test_write(18'h00012, 16'hA5C3);
    test_read(18'h00012);
    test_back_to_back();
    test_reset_mid_read();
    test_read(18'h00012);
`ifdef SRAM_TURNAROUND_EN
    test_turn();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_ctrl_async.md
Name: sram_ctrl_async

Overview:
- Parametrised successor to the single-port SRAM write strobe controller.
- Drives an external asynchronous SRAM (active-low CSX/OEX/WEX, bidirectional DATA, address bus) from a simple req/ready internal interface.
- Supports both reads and writes with configurable wait states and a write data-hold cycle.
- Sits between the CPU/memory-map logic and the FPGA pins.

Parameters:
- DATA_W, 16, data bus width in bits.
- ADDR_W, 18, SRAM address width in bits.
- WAIT_CYCLES, 2, clock cycles each strobe (WEX or OEX) is held low; must be >= 1, elaboration error otherwise.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  access request, sampled only when ready=1.
- we  input  1  1=write, 0=read; sampled with req.
- addr  input  ADDR_W  access address; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- ready  output  1  controller idle, can accept req this cycle.
- rdata  output  DATA_W  last read data, held until next read completes.
- rvalid  output  1  one-cycle pulse, rdata updated.
- CSX  output  1  SRAM chip select, active low.
- OEX  output  1  SRAM output enable, active low.
- WEX  output  1  SRAM write enable, active low.
- ADDR  output  ADDR_W  SRAM address, registered.
- DATA  inout  DATA_W  SRAM data; driven only in WR and WR_HOLD, else high-Z.

Behaviour:
- Clock is clk; reset is asynchronous, active-high.
- Reset values: state=IDLE, CSX=OEX=WEX=1, DATA=Z, ADDR=0, rdata=0, rvalid=0, wait counter=0.
- ready = (state==IDLE) & ~reset; combinational from state.
- Strobes and ADDR are registered; no combinational path from req to pins.
- Acceptance: req&ready at edge E0 latches addr/we/wdata. req while ready=0 is ignored, not queued.
- States:
  - IDLE: CSX=OEX=WEX=1, DATA=Z.
  - WR: CSX=0, WEX=0, OEX=1, DATA=latched wdata. Lasts WAIT_CYCLES cycles, then WR_HOLD.
  - WR_HOLD: CSX=0, WEX=1, OEX=1, DATA still driven. Lasts 1 cycle, then IDLE.
  - RD: CSX=0, OEX=0, WEX=1, DATA=Z. Lasts WAIT_CYCLES cycles.
  - On the last RD edge: DATA sampled into rdata, rvalid=1 for the following cycle, next state IDLE (or TURN, see Optional Feature).
- Latency, write: ready low for WAIT_CYCLES+1 cycles after E0; ready high again after edge E0+WAIT_CYCLES+1.
- Latency, read: rdata/rvalid valid in the cycle after edge E0+WAIT_CYCLES.
- Back-to-back: with req held high, at least one IDLE cycle separates accesses, because acceptance happens in IDLE.
- Wait counter: width $clog2(WAIT_CYCLES+1); cleared on entry to WR/RD; it never wraps.
- ADDR holds its last value in IDLE.
- DATA is never driven while OEX=0.
- Reset mid-operation: immediately forces IDLE, strobes high, DATA=Z, rvalid=0; rdata is cleared to 0. The aborted access produces no rvalid.
- Reset has priority over acceptance in the same cycle.

Optional Feature:
- Macro: SRAM_TURNAROUND_EN.
- Defined: after the last RD cycle, the controller enters TURN for 1 cycle (CSX=OEX=WEX=1, DATA=Z, ready=0), then IDLE. This gives one bus-turnaround cycle before the FPGA can drive DATA again. rvalid timing is unchanged: the pulse occurs during TURN.
- Undefined: RD goes directly to IDLE and the TURN state does not exist.

Test Plan (WAIT_CYCLES=2, ADDR_W=18, DATA_W=16, behavioural SRAM model):
- Reset asserted mid-cycle, asynchronously -> CSX=OEX=WEX=1, DATA=Z, rdata=0, rvalid=0, ready=0 before the next edge. After release, ready=1.
- Write addr=0x00012, wdata=0xA5C3 -> two cycles with CSX=0, WEX=0, DATA=0xA5C3, ADDR=0x00012; then one hold cycle with WEX=1 and DATA=0xA5C3; then ready=1. The model holds 0xA5C3 at 0x00012.
- Read addr=0x00012 -> two cycles with OEX=0 and DATA=Z from the controller; then rvalid=1 for exactly one cycle with rdata=0xA5C3. rdata is held afterwards.
- req held high: write 0x3FFFF<-0xFFFF, then read 0x3FFFF -> exactly one IDLE cycle between accesses, rdata=0xFFFF; no DATA contention (OEX=0 never coincides with the controller driving DATA).
- Reset asserted during the first RD cycle -> strobes high in the same cycle, no rvalid pulse, rdata=0. A new read afterwards completes normally.
- With SRAM_TURNAROUND_EN: read then write -> one cycle with CSX=1 and ready=0 after RD. rvalid pulses during that cycle, and WEX falls no earlier than 2 cycles after OEX rises.
